// File: rtl/run_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : run_monitor_if
// Description : Bundles the signals between run_monitor and the CPU it controls.
//               This covers CPU control and trace, register-file and data-memory
//               read ports, the dump word stream, and run status.
// Revision    : 1.0 - initial release
// ============================================================================
interface run_monitor_if #(
  parameter int unsigned CNT_W = 16
) ();

  // Run control and CPU trace
  logic             start;
  logic [31:0]      pc_i;
  logic [31:0]      inst_i;
  logic             cpu_stall;
  logic             trace_valid;

  // Register-file and data-memory read ports (asynchronous read on the far side)
  logic [4:0]       rf_raddr;
  logic [31:0]      rf_rdata;
  logic [31:0]      dm_raddr;
  logic [31:0]      dm_rdata;

  // Dump word stream and status
  logic             dump_valid;
  logic             dump_sel;
  logic [7:0]       dump_idx;
  logic [31:0]      dump_data;
  logic             done;
  logic [1:0]       stop_reason;
  logic [CNT_W-1:0] cycle_cnt;

  // Monitor side: drives CPU control, read addresses and the dump stream
  modport master (
    input  start, pc_i, inst_i, rf_rdata, dm_rdata,
    output cpu_stall, trace_valid, rf_raddr, dm_raddr,
           dump_valid, dump_sel, dump_idx, dump_data,
           done, stop_reason, cycle_cnt
  );

  // CPU / capture side
  modport slave (
    output start, pc_i, inst_i, rf_rdata, dm_rdata,
    input  cpu_stall, trace_valid, rf_raddr, dm_raddr,
           dump_valid, dump_sel, dump_idx, dump_data,
           done, stop_reason, cycle_cnt
  );

endinterface : run_monitor_if
`default_nettype wire

// File: rtl/run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : run_monitor
// Description : Run-control and state-dump unit for the single-cycle CPU.
//               The unit lets the CPU run and counts committed cycles. It stops
//               the CPU on a cycle limit, a halt PC or a self-loop. It then
//               streams out the register file, followed by a window of data
//               memory, one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module run_monitor #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 16,
  parameter bit          HALT_EN    = 1'b0,
  parameter logic [31:0] HALT_PC    = 32'h0000_3000,
  parameter int unsigned LOOP_LIMIT = 4,
  parameter int unsigned NUM_REGS   = 32,
  parameter logic [31:0] MEM_BASE   = 32'd80,
  parameter int unsigned NUM_MEM    = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,   // asynchronous, active-low
  run_monitor_if.master  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LIMIT     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] C_LOOP      = CNT_W'(LOOP_LIMIT);
  localparam logic [7:0]       C_REG_LAST  = 8'(NUM_REGS - 1);
  localparam logic [7:0]       C_MEM_LAST  = 8'(NUM_MEM - 1);
  localparam bit               C_LIMIT_ON  = (MAX_CYCLES != 0);
  localparam bit               C_LOOP_ON   = (LOOP_LIMIT != 0);
  localparam bit               C_MEM_ON    = (NUM_MEM != 0);

  localparam logic [1:0] C_REASON_NONE  = 2'd0;
  localparam logic [1:0] C_REASON_LIMIT = 2'd1;
  localparam logic [1:0] C_REASON_HALT  = 2'd2;
  localparam logic [1:0] C_REASON_LOOP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_DUMP_REG = 3'd2,
    S_DUMP_MEM = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [1:0]       reason_q,     reason_d;
  logic [CNT_W-1:0] loop_q,       loop_d;
  logic [31:0]      prev_pc_q,    prev_pc_d;
  logic             prev_vld_q,   prev_vld_d;
  logic [7:0]       idx_q,        idx_d;
  logic [4:0]       rf_raddr_q,   rf_raddr_d;
  logic [31:0]      dm_raddr_q,   dm_raddr_d;
  logic             dump_vld_q,   dump_vld_d;
  logic             dump_sel_q,   dump_sel_d;
  logic [7:0]       dump_idx_q,   dump_idx_d;
  logic [31:0]      dump_data_q,  dump_data_d;
  logic             done_q,       done_d;

  // --------------------------------------------------------------------------
  // Stop-condition evaluation for the current RUN cycle
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_loop_inc;
  logic             w_pc_same;
  logic             w_hit_limit;
  logic             w_hit_halt;
  logic             w_hit_loop;

  // The count saturates rather than wrapping, so a long unlimited run never reads back as short.
  assign w_cnt_inc   = (cnt_q == C_CNT_MAX) ? cnt_q : (cnt_q + C_CNT_ONE);

  // The first RUN cycle has no predecessor, so it can never look like a self-loop.
  assign w_pc_same   = prev_vld_q && (bus.pc_i == prev_pc_q);
  assign w_loop_inc  = !w_pc_same ? '0 :
                       ((loop_q == C_CNT_MAX) ? loop_q : (loop_q + C_CNT_ONE));

  // Every condition uses the post-increment count, so the stopping cycle itself is counted.
  assign w_hit_limit = C_LIMIT_ON && (w_cnt_inc == C_LIMIT);
  assign w_hit_halt  = HALT_EN && (bus.pc_i == HALT_PC);
  assign w_hit_loop  = C_LOOP_ON && (w_loop_inc == C_LOOP);

  // Next-state and datapath update for the run/dump sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reason_d    = reason_q;
    loop_d      = loop_q;
    prev_pc_d   = prev_pc_q;
    prev_vld_d  = prev_vld_q;
    idx_d       = idx_q;
    rf_raddr_d  = rf_raddr_q;
    dm_raddr_d  = dm_raddr_q;
    dump_vld_d  = 1'b0;
    dump_sel_d  = dump_sel_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // done rises one cycle after the final dump word, then holds
        done_d = (state_q == S_DONE);
        if (bus.start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          reason_d   = C_REASON_NONE;
          loop_d     = '0;
          prev_vld_d = 1'b0;
          done_d     = 1'b0;
        end
      end

      S_RUN: begin
        cnt_d      = w_cnt_inc;
        loop_d     = w_loop_inc;
        prev_pc_d  = bus.pc_i;
        prev_vld_d = 1'b1;
        if (w_hit_limit || w_hit_halt || w_hit_loop) begin
          if (w_hit_limit) begin
            reason_d = C_REASON_LIMIT;
          end else if (w_hit_halt) begin
            reason_d = C_REASON_HALT;
          end else begin
            reason_d = C_REASON_LOOP;
          end
          state_d    = S_DUMP_REG;
          idx_d      = '0;
          rf_raddr_d = '0;
        end
      end

      S_DUMP_REG: begin
        // x0 is hard-wired to zero on the CPU, so its dump does not depend on the read port
        dump_vld_d  = 1'b1;
        dump_sel_d  = 1'b0;
        dump_idx_d  = idx_q;
        dump_data_d = (idx_q == 8'd0) ? 32'd0 : bus.rf_rdata;
        if (idx_q == C_REG_LAST) begin
          idx_d      = '0;
          dm_raddr_d = MEM_BASE;
          state_d    = C_MEM_ON ? S_DUMP_MEM : S_DONE;
        end else begin
          idx_d      = idx_q + 8'd1;
          rf_raddr_d = rf_raddr_q + 5'd1;
        end
      end

      S_DUMP_MEM: begin
        dump_vld_d  = 1'b1;
        dump_sel_d  = 1'b1;
        dump_idx_d  = idx_q;
        dump_data_d = bus.dm_rdata;
        if (idx_q == C_MEM_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d      = idx_q + 8'd1;
          dm_raddr_d = dm_raddr_q + 32'd4;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run or dump in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      reason_q    <= C_REASON_NONE;
      loop_q      <= '0;
      prev_pc_q   <= '0;
      prev_vld_q  <= 1'b0;
      idx_q       <= '0;
      rf_raddr_q  <= '0;
      dm_raddr_q  <= MEM_BASE;
      dump_vld_q  <= 1'b0;
      dump_sel_q  <= 1'b0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reason_q    <= reason_d;
      loop_q      <= loop_d;
      prev_pc_q   <= prev_pc_d;
      prev_vld_q  <= prev_vld_d;
      idx_q       <= idx_d;
      rf_raddr_q  <= rf_raddr_d;
      dm_raddr_q  <= dm_raddr_d;
      dump_vld_q  <= dump_vld_d;
      dump_sel_q  <= dump_sel_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
      done_q      <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cpu_stall   = (state_q != S_RUN);
  assign bus.trace_valid = (state_q == S_RUN);
  assign bus.rf_raddr    = rf_raddr_q;
  assign bus.dm_raddr    = dm_raddr_q;
  assign bus.dump_valid  = dump_vld_q;
  assign bus.dump_sel    = dump_sel_q;
  assign bus.dump_idx    = dump_idx_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.done        = done_q;
  assign bus.stop_reason = reason_q;
  assign bus.cycle_cnt   = cnt_q;

endmodule : run_monitor
`default_nettype wire

// File: tb/tb_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_monitor
// Description : Randomised self-checking bench for run_monitor. A stimulus
//               process plays a PC trace for each run, and a monitor process
//               compares the dump stream and run summary against expectations
//               queued from a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_monitor;

  localparam int unsigned MAXC  = 40;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LOOPL = 4;
  localparam int unsigned NREG  = 32;
  localparam int unsigned NMEM  = 2;
  localparam logic [31:0] HPC   = 32'h0000_3010;
  localparam logic [31:0] MBASE = 32'd80;
  localparam int          NRUNS = 14;

  typedef struct packed {
    logic        sel;
    logic [7:0]  idx;
    logic [31:0] data;
  } dump_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic [1:0]  reason;
  } run_t;

  logic clk;
  logic rst;

  int tests;
  int fails;

  dump_t exp_q[$];
  run_t  run_q[$];

  logic [31:0] regs [0:31];
  logic [31:0] mem  [0:63];
  logic [31:0] plan [0:63];

  run_monitor_if #(.CNT_W(CNT_W)) bus ();

  run_monitor #(
    .MAX_CYCLES (MAXC),
    .CNT_W      (CNT_W),
    .HALT_EN    (1'b1),
    .HALT_PC    (HPC),
    .LOOP_LIMIT (LOOPL),
    .NUM_REGS   (NREG),
    .MEM_BASE   (MBASE),
    .NUM_MEM    (NMEM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Asynchronous-read register file and data memory
  assign bus.rf_rdata = regs[bus.rf_raddr];
  assign bus.dm_rdata = mem[bus.dm_raddr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cpu_stall",   64'(bus.cpu_stall),   64'd1);
    check("rst_trace_valid", 64'(bus.trace_valid), 64'd0);
    check("rst_dump_valid",  64'(bus.dump_valid),  64'd0);
    check("rst_done",        64'(bus.done),        64'd0);
    check("rst_stop_reason", 64'(bus.stop_reason), 64'd0);
    check("rst_cycle_cnt",   64'(bus.cycle_cnt),   64'd0);
    check("rst_rf_raddr",    64'(bus.rf_raddr),    64'd0);
    check("rst_dm_raddr",    64'(bus.dm_raddr),    64'(MBASE));
    check("rst_dump_sel",    64'(bus.dump_sel),    64'd0);
    check("rst_dump_idx",    64'(bus.dump_idx),    64'd0);
    check("rst_dump_data",   64'(bus.dump_data),   64'd0);
  endtask

  // Reference model: walk the committed PC trace cycle by cycle and apply the stop rules.
  function automatic run_t model_run();
    run_t r;
    int   same;
    r.cnt    = 16'd0;
    r.reason = 2'd0;
    same     = 0;
    for (int c = 1; c <= 64; c++) begin
      if (c > 1 && plan[c-1] == plan[c-2]) same++;
      else same = 0;
      if (c == int'(MAXC)) begin
        r.cnt = 16'(c); r.reason = 2'd1; return r;
      end
      if (plan[c-1] == HPC) begin
        r.cnt = 16'(c); r.reason = 2'd2; return r;
      end
      if (same == int'(LOOPL)) begin
        r.cnt = 16'(c); r.reason = 2'd3; return r;
      end
    end
    return r;
  endfunction

  // PC trace kinds: 0 straight line, 1 halt PC, 2 self-loop, 3 halt on the limit cycle,
  // 4 random pick from a tiny PC set, 5 constant PC from the first cycle.
  task automatic build_plan(input int kind);
    logic [31:0] base;
    int h;
    int j;
    base = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 8);
    for (int i = 0; i < 64; i++) plan[i] = base + 32'(4 * i);
    case (kind)
      1: begin
        h = $urandom_range(1, 39);
        plan[h-1] = HPC;
      end
      2: begin
        j = $urandom_range(2, 30);
        for (int i = j - 1; i < 64; i++) plan[i] = base + 32'(4 * (j - 1));
      end
      3: plan[MAXC-1] = HPC;
      4: begin
        for (int i = 0; i < 64; i++)
          plan[i] = ($urandom_range(0, 15) == 0) ? HPC : (base + 32'(4 * $urandom_range(0, 1)));
      end
      5: begin
        for (int i = 0; i < 64; i++) plan[i] = base;
      end
      default: ;
    endcase
  endtask

  task automatic queue_expectations();
    run_t r;
    dump_t e;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 64; i++) mem[i]  = $urandom;
    r = model_run();
    run_q.push_back(r);
    for (int i = 0; i < int'(NREG); i++) begin
      e.sel  = 1'b0;
      e.idx  = 8'(i);
      e.data = (i == 0) ? 32'd0 : regs[i];
      exp_q.push_back(e);
    end
    for (int k = 0; k < int'(NMEM); k++) begin
      e.sel  = 1'b1;
      e.idx  = 8'(k);
      e.data = mem[(int'(MBASE) + 4 * k) / 4];
      exp_q.push_back(e);
    end
  endtask

  // Plays one run as the CPU would: the PC advances only on cycles the monitor lets commit.
  task automatic do_run(input bit abort);
    int n;
    bit seen_done;
    n = 0;
    seen_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.trace_valid) begin
        bus.pc_i   = plan[n];
        bus.inst_i = $urandom;
        n++;
        // start pulses while running must be ignored
        if ($urandom_range(0, 7) == 0) bus.start = 1'b1;
      end
      if (abort && bus.dump_valid && !bus.dump_sel && bus.dump_idx == 8'd10) begin
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        run_q.delete();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: actual done=0 required done=1 within 300 cycles");
      rst = 1'b0;
      @(negedge clk);
      exp_q.delete();
      run_q.delete();
      rst = 1'b1;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a dump word or finishes a run
  initial begin : monitor
    int    trace_cnt;
    logic  prev_dv;
    logic  prev_done;
    dump_t e;
    run_t  r;
    trace_cnt = 0;
    prev_dv   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        trace_cnt = 0;
        prev_dv   = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (bus.trace_valid) trace_cnt++;
        if (bus.dump_valid) begin
          check("dump_stall", 64'(bus.cpu_stall), 64'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dump_extra: actual sel=%0d idx=%0d required no word",
                     bus.dump_sel, bus.dump_idx);
          end else begin
            e = exp_q.pop_front();
            check("dump_sel",  64'(bus.dump_sel),  64'(e.sel));
            check("dump_idx",  64'(bus.dump_idx),  64'(e.idx));
            check("dump_data", 64'(bus.dump_data), 64'(e.data));
          end
        end
        if (bus.done && !prev_done) begin
          check("done_after_last_dump", 64'(prev_dv), 64'd1);
          check("dump_words_left", 64'(exp_q.size()), 64'd0);
          if (run_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL run_extra: actual done rose required no run pending");
          end else begin
            r = run_q.pop_front();
            check("cycle_cnt",   64'(bus.cycle_cnt),   64'(r.cnt));
            check("stop_reason", 64'(bus.stop_reason), 64'(r.reason));
            check("trace_count", 64'(trace_cnt),       64'(r.cnt));
          end
          check("done_stall", 64'(bus.cpu_stall), 64'd1);
          trace_cnt = 0;
        end
        prev_dv   = bus.dump_valid;
        prev_done = bus.done;
      end
    end
  end

  // Stimulus: reset checks, then a series of randomised runs, one aborted mid-dump
  initial begin : stim
    int kind;
    tests = 0;
    fails = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.pc_i   = 32'd0;
    bus.inst_i = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) mem[i]  = 32'd0;
    for (int i = 0; i < 64; i++) plan[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_stall_no_start", 64'(bus.cpu_stall), 64'd1);

    for (int r = 0; r < NRUNS; r++) begin
      kind = (r < 6) ? r : $urandom_range(0, 5);
      build_plan(kind);
      queue_expectations();
      do_run(r == 7);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_run_monitor
`default_nettype wire
